// File: rtl/playseq_uc_param.sv
// PlaySeq control unit: one FSM with address (E), round (S), length (L), timer and lives
// counters, driving an external sequence RAM. Optional lives feature: PLAYSEQ_VIDAS_EN.
module playseq_uc_param #(
    parameter int NB       = 4,
    parameter int PROF     = 16,
    parameter int T_JOGADA = 5000,
    parameter int T_LED    = 1000,
    parameter int VIDAS    = 3,
    localparam int AW      = (PROF > 1) ? $clog2(PROF) : 1
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          jogar,
    input  logic [1:0]    modo,
    input  logic [AW:0]   tam,
    input  logic [NB-1:0] jogada,
    input  logic [NB-1:0] dado_mem,
    output logic [AW-1:0] endereco,
    output logic          ram_we,
    output logic [NB-1:0] ram_dado,
    output logic [NB-1:0] leds,
    output logic          pronto,
    output logic          ganhou,
    output logic          perdeu,
    output logic          deu_timeout,
    output logic [1:0]    vidas_rest,
    output logic [AW-1:0] rodada,
    output logic [4:0]    db_estado
);

    localparam int TMAX = (T_JOGADA > T_LED) ? T_JOGADA : T_LED;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] T_JOG_LAST = TW'(T_JOGADA - 1);
    localparam logic [TW-1:0] T_LED_LAST = TW'(T_LED - 1);
    localparam logic [AW:0]   PROF_W     = (AW+1)'(PROF);

    typedef enum logic [4:0] {
        INICIAL       = 5'h00,
        PREPARA       = 5'h01,
        NOVA_RODADA   = 5'h02,
        ESPERA        = 5'h03,
        REGISTRA      = 5'h04,
        COMPARA       = 5'h05,
        PROXIMO       = 5'h06,
        ERRO_VIDA     = 5'h07,
        GRAVA_ESCREVE = 5'h09,
        FIM_ACERTO    = 5'h0A,
        MOSTRA        = 5'h0B,
        APAGA         = 5'h0C,
        INICIA_RODADA = 5'h0D,
        FIM_ERRO      = 5'h0E,
        FIM_TIMEOUT   = 5'h0F,
        GRAVA_ESPERA  = 5'h10,
        GRAVA_REG     = 5'h11,
        GRAVA_FIM     = 5'h12
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   e_q, e_d;
    logic [AW-1:0]   s_q, s_d;
    logic [AW-1:0]   l_q, l_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [NB-1:0]   jogada_prev_q, jogada_prev_d;
    logic [NB-1:0]   jogada_reg_q, jogada_reg_d;
`ifdef PLAYSEQ_VIDAS_EN
    logic [1:0]      vidas_q, vidas_d;
`endif

    logic            tem_jogada;
    logic [AW:0]     tam_clamp;
    logic [AW-1:0]   l_new;

    // A move is the first cycle of a non-zero vector after an all-released cycle.
    assign tem_jogada    = (jogada != '0) && (jogada_prev_q == '0);
    assign jogada_prev_d = jogada;

    always_comb begin
        tam_clamp = tam;
        if (tam == '0) begin
            tam_clamp = (AW+1)'(1);
        end else if (tam > PROF_W) begin
            tam_clamp = PROF_W;
        end
        l_new = AW'(tam_clamp - (AW+1)'(1));
    end

    // State register and datapath registers.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q       <= INICIAL;
            e_q           <= '0;
            s_q           <= '0;
            l_q           <= '0;
            timer_q       <= '0;
            jogada_prev_q <= '0;
            jogada_reg_q  <= '0;
`ifdef PLAYSEQ_VIDAS_EN
            vidas_q       <= 2'(VIDAS);
`endif
        end else begin
            state_q       <= state_d;
            e_q           <= e_d;
            s_q           <= s_d;
            l_q           <= l_d;
            timer_q       <= timer_d;
            jogada_prev_q <= jogada_prev_d;
            jogada_reg_q  <= jogada_reg_d;
`ifdef PLAYSEQ_VIDAS_EN
            vidas_q       <= vidas_d;
`endif
        end
    end

    // Next state and counter updates; the timer clears in every state that does not count.
    always_comb begin
        state_d      = state_q;
        e_d          = e_q;
        s_d          = s_q;
        l_d          = l_q;
        timer_d      = '0;
        jogada_reg_d = jogada_reg_q;
`ifdef PLAYSEQ_VIDAS_EN
        vidas_d      = vidas_q;
`endif
        case (state_q)
            INICIAL: begin
                if (jogar) state_d = PREPARA;
            end
            PREPARA: begin
                l_d = l_new;
                e_d = '0;
                s_d = (modo == 2'b00 || modo == 2'b11) ? l_new : '0;
`ifdef PLAYSEQ_VIDAS_EN
                vidas_d = 2'(VIDAS);
`endif
                state_d = (modo == 2'b10) ? GRAVA_ESPERA : MOSTRA;
            end
            GRAVA_ESPERA: begin
                if (tem_jogada) state_d = GRAVA_REG;
            end
            GRAVA_REG: begin
                jogada_reg_d = jogada;
                state_d      = GRAVA_ESCREVE;
            end
            GRAVA_ESCREVE: begin
                if (e_q == l_q) begin
                    e_d     = '0;
                    state_d = GRAVA_FIM;
                end else begin
                    e_d     = e_q + AW'(1);
                    state_d = GRAVA_ESPERA;
                end
            end
            GRAVA_FIM: begin
                if (jogar) state_d = MOSTRA;
            end
            MOSTRA: begin
                if (timer_q == T_LED_LAST) state_d = APAGA;
                else timer_d = timer_q + TW'(1);
            end
            APAGA: begin
                if (timer_q == T_LED_LAST) begin
                    if (e_q == s_q) begin
                        state_d = INICIA_RODADA;
                    end else begin
                        e_d     = e_q + AW'(1);
                        state_d = MOSTRA;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            INICIA_RODADA: begin
                e_d     = '0;
                state_d = ESPERA;
            end
            ESPERA: begin
                // Timeout is checked first so it wins over a press in the same cycle.
                if (timer_q == T_JOG_LAST) begin
                    state_d = FIM_TIMEOUT;
                end else begin
                    timer_d = timer_q + TW'(1);
                    if (tem_jogada) state_d = REGISTRA;
                end
            end
            REGISTRA: begin
                jogada_reg_d = jogada;
                state_d      = COMPARA;
            end
            COMPARA: begin
                if (jogada_reg_q == dado_mem) begin
                    if (e_q != s_q)      state_d = PROXIMO;
                    else if (s_q == l_q) state_d = FIM_ACERTO;
                    else                 state_d = NOVA_RODADA;
                end else begin
`ifdef PLAYSEQ_VIDAS_EN
                    state_d = (vidas_q > 2'd1) ? ERRO_VIDA : FIM_ERRO;
`else
                    state_d = FIM_ERRO;
`endif
                end
            end
            PROXIMO: begin
                e_d     = e_q + AW'(1);
                state_d = ESPERA;
            end
            NOVA_RODADA: begin
                s_d     = s_q + AW'(1);
                e_d     = '0;
                state_d = MOSTRA;
            end
`ifdef PLAYSEQ_VIDAS_EN
            ERRO_VIDA: begin
                vidas_d = vidas_q - 2'd1;
                e_d     = '0;
                state_d = MOSTRA;
            end
`endif
            FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT: begin
                if (jogar) state_d = PREPARA;
            end
            default: state_d = INICIAL;
        endcase
    end

    // Moore outputs; leds echoes the buttons except during the preview.
    always_comb begin
        ram_we      = 1'b0;
        pronto      = 1'b0;
        ganhou      = 1'b0;
        perdeu      = 1'b0;
        deu_timeout = 1'b0;
        leds        = jogada;
        case (state_q)
            MOSTRA:        leds = dado_mem;
            APAGA:         leds = '0;
            GRAVA_ESCREVE: ram_we = 1'b1;
            FIM_ACERTO: begin
                pronto = 1'b1;
                ganhou = 1'b1;
            end
            FIM_ERRO: begin
                pronto = 1'b1;
                perdeu = 1'b1;
            end
            FIM_TIMEOUT: begin
                pronto      = 1'b1;
                perdeu      = 1'b1;
                deu_timeout = 1'b1;
            end
            default: ;
        endcase
    end

    assign endereco  = e_q;
    assign rodada    = s_q;
    assign ram_dado  = jogada_reg_q;
    assign db_estado = state_q;
`ifdef PLAYSEQ_VIDAS_EN
    assign vidas_rest = vidas_q;
`else
    // Without the lives counter the reported count is always zero.
    assign vidas_rest = 2'(VIDAS) & 2'b00;
`endif

endmodule

// File: tb/tb_playseq_uc_param.sv
// Bench for playseq_uc_param: a per-cycle vector table for one short game, then
// directed multi-cycle sequences (reset, modes, recording, lives, timeout).
module tb_playseq_uc_param;

    localparam int NB = 4;
    localparam int PROF = 4;
    localparam int AW = 2;
    localparam int T_JOGADA = 8;
    localparam int T_LED = 2;
    localparam int VIDAS = 2;
`ifdef PLAYSEQ_VIDAS_EN
    localparam logic [1:0] EXP_V = 2'd2;
`else
    localparam logic [1:0] EXP_V = 2'd0;
`endif

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          jogar = 1'b0;
    logic [1:0]    modo = 2'b00;
    logic [AW:0]   tam = '0;
    logic [NB-1:0] jogada = '0;
    logic [NB-1:0] dado_mem;
    logic [AW-1:0] endereco;
    logic          ram_we;
    logic [NB-1:0] ram_dado;
    logic [NB-1:0] leds;
    logic          pronto, ganhou, perdeu, deu_timeout;
    logic [1:0]    vidas_rest;
    logic [AW-1:0] rodada;
    logic [4:0]    db_estado;

    logic [NB-1:0] mem [PROF];
    logic [AW-1:0] we_addr_q [$];
    logic [NB-1:0] we_data_q [$];

    int n_checks = 0;
    int n_pass = 0;

    assign dado_mem = mem[endereco];

    playseq_uc_param #(
        .NB(NB), .PROF(PROF), .T_JOGADA(T_JOGADA), .T_LED(T_LED), .VIDAS(VIDAS)
    ) dut (
        .clock(clock), .reset_n(reset_n), .jogar(jogar), .modo(modo), .tam(tam),
        .jogada(jogada), .dado_mem(dado_mem), .endereco(endereco), .ram_we(ram_we),
        .ram_dado(ram_dado), .leds(leds), .pronto(pronto), .ganhou(ganhou),
        .perdeu(perdeu), .deu_timeout(deu_timeout), .vidas_rest(vidas_rest),
        .rodada(rodada), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // One clock: the RAM model and write log see the current Moore outputs, then the edge.
    task automatic step();
        if (ram_we === 1'b1) begin
            mem[endereco] = ram_dado;
            we_addr_q.push_back(endereco);
            we_data_q.push_back(ram_dado);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        jogar = 1'b0;
        jogada = '0;
        step();
        reset_n = 1'b1;
    endtask

    task automatic start_game(input logic [1:0] m, input logic [AW:0] t);
        modo = m;
        tam = t;
        jogar = 1'b1;
        step();
        jogar = 1'b0;
        check("start_prepara", db_estado, 5'h01);
    endtask

    // Press cycle k, REGISTRA k+1, COMPARA k+2; returns in the state entered at k+3.
    task automatic press(input logic [NB-1:0] b);
        jogada = b;
        step();
        step();
        jogada = '0;
        step();
    endtask

    task automatic wait_state(input logic [4:0] st, input int budget, input string name);
        int n = 0;
        while (db_estado !== st && n < budget) begin
            step();
            n++;
        end
        check(name, db_estado, st);
    endtask

    // Counts preview elements (MOSTRA entries) until ESPERA, logging LED values.
    task automatic preview(output int n_el, output logic [15:0] seen);
        int n = 0;
        logic was = 1'b0;
        n_el = 0;
        seen = '0;
        while (db_estado !== 5'h03 && n < 200) begin
            if (db_estado === 5'h0B && !was) begin
                seen = {seen[11:0], leds};
                n_el++;
            end
            was = (db_estado === 5'h0B);
            step();
            n++;
        end
        check("preview_reaches_espera", db_estado, 5'h03);
    endtask

    typedef struct {
        logic          rst_n;
        logic          jogar;
        logic [1:0]    modo;
        logic [AW:0]   tam;
        logic [NB-1:0] jogada;
        logic [4:0]    st;
        logic [NB-1:0] leds;
        logic [3:0]    flags;  // {pronto, ganhou, perdeu, deu_timeout}
        logic          we;
    } vec_t;

    vec_t vecs [14];

    initial begin
        int n_el;
        logic [15:0] seen;

        for (int i = 0; i < PROF; i++) mem[i] = '0;
        mem[0] = 4'h4;

        // Mode 00 with tam=0 (clamps to one element), correct move, then restart.
        vecs[0]  = '{1'b0, 1'b0, 2'd0, 3'd0, 4'h0, 5'h00, 4'h0, 4'b0000, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 2'd0, 3'd0, 4'h0, 5'h00, 4'h0, 4'b0000, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 2'd0, 3'd0, 4'h0, 5'h01, 4'h0, 4'b0000, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 2'd0, 3'd0, 4'h0, 5'h0B, 4'h4, 4'b0000, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 2'd0, 3'd0, 4'h0, 5'h0B, 4'h4, 4'b0000, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 2'd0, 3'd0, 4'h0, 5'h0C, 4'h0, 4'b0000, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 2'd0, 3'd0, 4'h0, 5'h0C, 4'h0, 4'b0000, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 2'd0, 3'd0, 4'h0, 5'h0D, 4'h0, 4'b0000, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 2'd0, 3'd0, 4'h0, 5'h03, 4'h0, 4'b0000, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 2'd0, 3'd0, 4'h4, 5'h04, 4'h4, 4'b0000, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 2'd0, 3'd0, 4'h4, 5'h05, 4'h4, 4'b0000, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 2'd0, 3'd0, 4'h0, 5'h0A, 4'h0, 4'b1100, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 2'd0, 3'd0, 4'h0, 5'h0A, 4'h0, 4'b1100, 1'b0};
        vecs[13] = '{1'b1, 1'b1, 2'd0, 3'd0, 4'h0, 5'h01, 4'h0, 4'b0000, 1'b0};

        for (int i = 0; i < 14; i++) begin
            reset_n = vecs[i].rst_n;
            jogar   = vecs[i].jogar;
            modo    = vecs[i].modo;
            tam     = vecs[i].tam;
            jogada  = vecs[i].jogada;
            step();
            check($sformatf("vec%0d_estado", i), db_estado, vecs[i].st);
            check($sformatf("vec%0d_leds", i), leds, vecs[i].leds);
            check($sformatf("vec%0d_flags", i), {pronto, ganhou, perdeu, deu_timeout}, vecs[i].flags);
            check($sformatf("vec%0d_we", i), ram_we, vecs[i].we);
        end
        check("vec_vidas_rest", vidas_rest, EXP_V);

        // Reset in the middle of a preview.
        mem[0] = 4'h1; mem[1] = 4'h2; mem[2] = 4'h4; mem[3] = 4'h8;
        do_reset();
        start_game(2'd0, 3'd4);
        wait_state(5'h0B, 10, "rst_reach_mostra");
        step();
        step();
        reset_n = 1'b0;
        step();
        check("rst_estado", db_estado, 5'h00);
        check("rst_leds", leds, 4'h0);
        check("rst_we", ram_we, 1'b0);
        check("rst_pronto", pronto, 1'b0);
        check("rst_endereco", endereco, 2'd0);
        check("rst_rodada", rodada, 2'd0);
        check("rst_vidas", vidas_rest, EXP_V);
        reset_n = 1'b1;

        // Mode 00, tam=4, all moves correct.
        we_addr_q.delete();
        do_reset();
        start_game(2'd0, 3'd4);
        preview(n_el, seen);
        check("m00_n_preview", n_el, 4);
        check("m00_preview_leds", seen, 16'h1248);
        check("m00_rodada", rodada, 2'd3);
        press(4'h1); check("m00_mv0", db_estado, 5'h06); step();
        press(4'h2); check("m00_mv1", db_estado, 5'h06); step();
        press(4'h4); check("m00_mv2", db_estado, 5'h06); step();
        press(4'h8); check("m00_fim", db_estado, 5'h0A);
        check("m00_flags", {pronto, ganhou, perdeu, deu_timeout}, 4'b1100);
        check("m00_no_writes", we_addr_q.size(), 0);

        // Mode 01, tam=3: rounds of 1, 2, 3 elements.
        do_reset();
        start_game(2'd1, 3'd3);
        for (int r = 0; r < 3; r++) begin
            preview(n_el, seen);
            check($sformatf("m01_r%0d_len", r), n_el, r + 1);
            check($sformatf("m01_r%0d_rodada", r), rodada, r);
            for (int j = 0; j <= r; j++) begin
                press(mem[j]);
                if (j < r) begin
                    check($sformatf("m01_r%0d_mv%0d", r, j), db_estado, 5'h06);
                    step();
                end
            end
            check($sformatf("m01_r%0d_end", r), db_estado, (r < 2) ? 5'h02 : 5'h0A);
        end

        // Mode 10, tam=2: record 4 then 2, then play back.
        for (int i = 0; i < PROF; i++) mem[i] = '0;
        we_addr_q.delete();
        we_data_q.delete();
        do_reset();
        start_game(2'd2, 3'd2);
        step();
        check("m10_grava_espera", db_estado, 5'h10);
        press(4'h4); check("m10_after_w0", db_estado, 5'h10);
        press(4'h2); check("m10_grava_fim", db_estado, 5'h12);
        step();
        check("m10_waits_jogar", db_estado, 5'h12);
        check("m10_we_count", we_addr_q.size(), 2);
        if (we_addr_q.size() == 2) begin
            check("m10_addr0", we_addr_q[0], 2'd0);
            check("m10_data0", we_data_q[0], 4'h4);
            check("m10_addr1", we_addr_q[1], 2'd1);
            check("m10_data1", we_data_q[1], 4'h2);
        end
        jogar = 1'b1; step(); jogar = 1'b0;
        check("m10_play_mostra", db_estado, 5'h0B);
        preview(n_el, seen);
        check("m10_r0_len", n_el, 1);
        check("m10_r0_led", seen[3:0], 4'h4);
        press(4'h4); check("m10_r0_end", db_estado, 5'h02);
        preview(n_el, seen);
        check("m10_r1_len", n_el, 2);
        check("m10_r1_leds", seen[7:0], 8'h42);
        press(4'h4); check("m10_r1_mv0", db_estado, 5'h06); step();
        press(4'h2); check("m10_fim", db_estado, 5'h0A);

        // Mismatch handling (multi-hot first), with or without lives.
        mem[0] = 4'h1; mem[1] = 4'h2;
        do_reset();
        start_game(2'd0, 3'd2);
        check("viv_initial", vidas_rest, EXP_V);
        preview(n_el, seen);
        press(4'h3);
`ifdef PLAYSEQ_VIDAS_EN
        check("viv_erro_vida", db_estado, 5'h07);
        step();
        check("viv_replay_mostra", db_estado, 5'h0B);
        check("viv_rest1", vidas_rest, 2'd1);
        check("viv_addr0", endereco, 2'd0);
        preview(n_el, seen);
        check("viv_replay_len", n_el, 2);
        press(4'h8);
`endif
        check("viv_fim_erro", db_estado, 5'h0E);
        check("viv_flags", {pronto, ganhou, perdeu, deu_timeout}, 4'b1010);

        // Timeout after T_JOGADA idle cycles, and a press in the timeout cycle.
        mem[0] = 4'h1;
        do_reset();
        start_game(2'd0, 3'd1);
        preview(n_el, seen);
        for (int i = 0; i < T_JOGADA - 1; i++) step();
        check("to_still_espera", db_estado, 5'h03);
        step();
        check("to_fim", db_estado, 5'h0F);
        check("to_flags", {pronto, ganhou, perdeu, deu_timeout}, 4'b1011);
        start_game(2'd0, 3'd1);
        preview(n_el, seen);
        for (int i = 0; i < T_JOGADA - 1; i++) step();
        jogada = 4'h1;
        step();
        jogada = '0;
        check("to_press_same_cycle", db_estado, 5'h0F);

        // Held button at ESPERA entry gives no move; jogar is ignored in ESPERA.
        do_reset();
        start_game(2'd0, 3'd1);
        wait_state(5'h0D, 50, "held_reach_inicia");
        jogada = 4'h1;
        step();
        check("held_espera", db_estado, 5'h03);
        jogar = 1'b1;
        step();
        check("held_no_move", db_estado, 5'h03);
        jogar = 1'b0;
        jogada = '0;
        step();
        press(4'h1);
        check("held_then_win", db_estado, 5'h0A);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
